// File: rtl/rfid_cmd_tx.sv
// rfid_cmd_tx: UART transmitter sending 5-byte command frames
// (HDR, cmd, arg, cmd^arg, TAIL) to the RFID reader.
//
// Ports:
//   clk    system clock
//   rst    asynchronous active-low reset
//   start  one-cycle send request, accepted when busy=0
//   cmd    command byte, latched on accept
//   arg    argument byte, latched on accept
//   txd    serial line to the reader, idles high
//   busy   high while a frame is in progress
//   done   one-cycle pulse after the final stop bit
//
// Build option: define RFID_TX_PARITY_EN for 8E1 framing
// (even parity bit between data bit 7 and the stop bit).
module rfid_cmd_tx #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD      = 9600,
    parameter logic [7:0]  HDR_BYTE  = 8'hAA,
    parameter logic [7:0]  TAIL_BYTE = 8'h55
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] cmd,
    input  logic [7:0] arg,
    output logic       txd,
    output logic       busy,
    output logic       done
);

    localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W    = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
`ifdef RFID_TX_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [2:0]       byte_idx;
    logic [7:0]       cmd_q;
    logic [7:0]       arg_q;
    logic [7:0]       chk_q;
    logic [7:0]       cur_byte;
    logic             baud_end;
    logic             accept;
    logic             last_byte;

    assign baud_end  = (baud_cnt == BAUD_LAST);
    assign accept    = (state == IDLE) && start;
    assign last_byte = (byte_idx == 3'd4);

    always_comb begin
        unique case (byte_idx)
            3'd0:    cur_byte = HDR_BYTE;
            3'd1:    cur_byte = cmd_q;
            3'd2:    cur_byte = arg_q;
            3'd3:    cur_byte = chk_q;
            default: cur_byte = TAIL_BYTE;
        endcase
    end

    // State register plus the counters and latched frame bytes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            cmd_q    <= '0;
            arg_q    <= '0;
            chk_q    <= '0;
            done     <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == STOP) && baud_end && last_byte;

            if (state == IDLE || baud_end)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;

            if (state != DATA)
                bit_cnt <= '0;
            else if (baud_end)
                bit_cnt <= bit_cnt + 1'b1;

            if (accept) begin
                cmd_q    <= cmd;
                arg_q    <= arg;
                chk_q    <= cmd ^ arg;
                byte_idx <= '0;
            end else if (state == STOP && baud_end && !last_byte) begin
                byte_idx <= byte_idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start) state_nxt = START;
            START: if (baud_end) state_nxt = DATA;
            DATA: begin
                if (baud_end && bit_cnt == 3'd7) begin
`ifdef RFID_TX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef RFID_TX_PARITY_EN
            PARITY: if (baud_end) state_nxt = STOP;
`endif
            STOP: begin
                if (baud_end)
                    state_nxt = last_byte ? IDLE : START;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // txd decodes straight from the state register so an
    // asynchronous reset forces the line high immediately.
    always_comb begin
        txd  = 1'b1;
        busy = (state != IDLE);
        unique case (state)
            START:   txd = 1'b0;
            DATA:    txd = cur_byte[bit_cnt];
`ifdef RFID_TX_PARITY_EN
            PARITY:  txd = ^cur_byte;
`endif
            default: txd = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_rfid_cmd_tx.sv
// tb_rfid_cmd_tx: directed self-checking bench for rfid_cmd_tx
// with CLK_FREQ=1000, BAUD=100 (10 clocks per bit).
module tb_rfid_cmd_tx;

    localparam int DIV = 10;
`ifdef RFID_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = 5 * NB * DIV;
    localparam int LOGN  = 1200;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] cmd;
    logic [7:0] arg;
    logic       txd;
    logic       busy;
    logic       done;

    rfid_cmd_tx #(
        .CLK_FREQ (1000),
        .BAUD     (100),
        .HDR_BYTE (8'hAA),
        .TAIL_BYTE(8'h55)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .cmd  (cmd),
        .arg  (arg),
        .txd  (txd),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic tx_log   [LOGN];
    logic busy_log [LOGN];
    logic done_log [LOGN];

    typedef struct packed {
        logic [7:0]  cmd;
        logic [7:0]  arg;
        int          poke_at;
        logic [7:0]  pcmd;
        logic [39:0] exp;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Record n negedge samples; optionally pulse start at index
    // poke_at, or in the first cycle where done is seen.
    task automatic capture(input int n, input int poke_at,
                           input logic [7:0] pc, input logic [7:0] pa,
                           input bit poke_done);
        bit poked = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tx_log[i]   = txd;
            busy_log[i] = busy;
            done_log[i] = done;
            start = 1'b0;
            if (i == poke_at) begin
                start = 1'b1;
                cmd   = pc;
                arg   = pa;
            end
            if (poke_done && done && !poked) begin
                poked = 1;
                start = 1'b1;
                cmd   = pc;
                arg   = pa;
            end
        end
    endtask

    task automatic decode(input int base, input int b,
                          output logic [7:0] d, output logic st,
                          output logic sp, output logic par);
        int o;
        o  = base + b * NB * DIV + DIV / 2;
        st = tx_log[o];
        for (int k = 0; k < 8; k++)
            d[k] = tx_log[o + (k + 1) * DIV];
        par = (NB == 11) ? tx_log[o + 9 * DIV] : 1'b0;
        sp  = tx_log[o + (NB - 1) * DIV];
    endtask

    task automatic check_frame(input string tag, input int base,
                               input logic [39:0] exp);
        logic [7:0] d;
        logic [7:0] e;
        logic st;
        logic sp;
        logic par;
        int   ferr;
        ferr = 0;
        for (int b = 0; b < 5; b++) begin
            decode(base, b, d, st, sp, par);
            e = exp[39 - 8 * b -: 8];
            check($sformatf("%s byte%0d", tag, b), d, e);
            if (st !== 1'b0 || sp !== 1'b1) ferr++;
`ifdef RFID_TX_PARITY_EN
            check($sformatf("%s par%0d", tag, b), par, ^e);
`endif
        end
        check($sformatf("%s framing", tag), ferr, 0);
    endtask

    task automatic count_log(input int lo, input int hi,
                             output int nb, output int nd);
        nb = 0;
        nd = 0;
        for (int i = lo; i < hi; i++) begin
            if (busy_log[i]) nb++;
            if (done_log[i]) nd++;
        end
    endtask

    initial begin
        int nb;
        int nd;
        int bad;
        int bp;
        logic e;
        logic [7:0] hdr;

        vecs[0] = '{8'h01, 8'h3C, -1,  8'h00, 40'hAA013C3D55};
        vecs[1] = '{8'hFF, 8'hFF, -1,  8'h00, 40'hAAFFFF0055};
        vecs[2] = '{8'hA5, 8'h5A, -1,  8'h00, 40'hAAA55AFF55};
        vecs[3] = '{8'h09, 8'h00, -1,  8'h00, 40'hAA09000955};
        vecs[4] = '{8'h01, 8'h3C, 100, 8'hFF, 40'hAA013C3D55};

        rst   = 1'b0;
        start = 1'b0;
        cmd   = 8'h00;
        arg   = 8'h00;
        repeat (5) @(negedge clk);
        check("rst txd", txd, 1);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        rst = 1'b1;
        @(negedge clk);
        check("post-rst txd", txd, 1);
        check("post-rst busy", busy, 0);
        check("post-rst done", done, 0);

        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            start = 1'b1;
            cmd   = vecs[v].cmd;
            arg   = vecs[v].arg;
            capture(FRAME + 150, vecs[v].poke_at, vecs[v].pcmd,
                    vecs[v].arg, 0);
            check_frame($sformatf("v%0d", v), 0, vecs[v].exp);
            count_log(0, FRAME + 150, nb, nd);
            check($sformatf("v%0d busy_len", v), nb, FRAME);
            check($sformatf("v%0d done_cnt", v), nd, 1);
            check($sformatf("v%0d busy_first", v), busy_log[0], 1);
            check($sformatf("v%0d done_at_fall", v),
                  {busy_log[FRAME - 1], busy_log[FRAME], done_log[FRAME]},
                  3'b101);
            if (v == 0) begin
                hdr = 8'hAA;
                bad = 0;
                for (int i = 0; i < NB * DIV; i++) begin
                    bp = i / DIV;
                    if (bp == 0)
                        e = 1'b0;
                    else if (bp <= 8)
                        e = hdr[bp - 1];
                    else if (NB == 11 && bp == 9)
                        e = ^hdr;
                    else
                        e = 1'b1;
                    if (tx_log[i] !== e) bad++;
                end
                check("hdr bit timing", bad, 0);
            end
        end

        // Back-to-back: start issued in the done cycle.
        @(negedge clk);
        start = 1'b1;
        cmd   = 8'h01;
        arg   = 8'h3C;
        capture(2 * FRAME + 60, -1, 8'h11, 8'h00, 1);
        check_frame("b2b f1", 0, 40'hAA013C3D55);
        check_frame("b2b f2", FRAME + 1, 40'hAA11001155);
        count_log(0, 2 * FRAME + 60, nb, nd);
        check("b2b busy_len", nb, 2 * FRAME);
        check("b2b done_cnt", nd, 2);
        check("b2b gap", {busy_log[FRAME - 1], busy_log[FRAME],
                          busy_log[FRAME + 1]}, 3'b101);
        check("b2b done2", done_log[2 * FRAME + 1], 1);

        // Asynchronous reset in the middle of a low data bit.
        @(negedge clk);
        start = 1'b1;
        cmd   = 8'h01;
        arg   = 8'h3C;
        capture(16, -1, 8'h00, 8'h00, 0);
        check("mid txd low", txd, 0);
        #2;
        rst = 1'b0;
        #1;
        check("mid-rst txd", txd, 1);
        check("mid-rst busy", busy, 0);
        capture(20, -1, 8'h00, 8'h00, 0);
        count_log(0, 20, nb, nd);
        check("mid-rst no done", nd, 0);
        rst = 1'b1;
        capture(DIV * 60, -1, 8'h00, 8'h00, 0);
        count_log(0, DIV * 60, nb, nd);
        check("post abort idle", nb + nd, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
